// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore control FSM sequencing the shared multicycle MIPS datapath
// (one memory, one ALU, one register file) through fetch/decode/execute/memory/writeback.
module multicycle_control_fsm #(
    parameter bit SUPPORT_ADDI = 1'b1,
    parameter bit SUPPORT_J    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       Branch,
    output logic       illegal_op,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    state_t     r_state;
    state_t     w_next;
    state_t     w_dec_next;
    logic [5:0] r_op;
    logic       w_addi;
    logic       w_j;

    // The opcode is latched in DECODE so MEMADR's lw/sw choice ignores later IR changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_op <= opcode;
        end
    end

    assign w_addi = SUPPORT_ADDI && (opcode == OP_ADDI);
    assign w_j    = SUPPORT_J && (opcode == OP_J);
    assign w_dec_next = (opcode == OP_RTYPE)                   ? S_EXEC   :
                        (opcode == OP_LW || opcode == OP_SW)   ? S_MEMADR :
                        (opcode == OP_BEQ)                     ? S_BEQ    :
                        w_addi                                 ? S_ADDIEX :
                        w_j                                    ? S_JUMP   : S_FETCH;

    always_comb begin
        w_next     = S_FETCH;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = (w_dec_next == S_FETCH);
                w_next     = w_dec_next;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (r_op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD   = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                Branch  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
        // Reset gates every output so the reset cycle never fetches or writes.
        if (reset) begin
            {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA} = '0;
            {ALUSrcB, ALUOp, PCSrc, PCWrite, Branch, illegal_op} = '0;
        end
        state = reset ? 4'd0 : r_state;
    end
endmodule
